// File: rtl/branch_ctrl_pkg.sv
// Shared branch-control types: redirect FSM states and the 3-bit branch field encoding.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    REDIRECT = 2'd2
  } br_state_e;

  // Branch field of the instruction word; zero means "not a branch".
  // Decoded upstream by the decoder and the condition unit.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JUMP = 3'd1,
    BR_BEQZ = 3'd2,
    BR_BNEZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_BSCO = 3'd6
  } br_op_e;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer: tracks one in-flight branch (predict-not-taken) and
// issues a one-cycle registered PC redirect plus IF/ID and ID/EX flush on a taken resolution.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              ex_resolve,
  input  logic              ex_brchcnd,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              pipe_stall,
  output logic              fetch_hold,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic              proto_err
);

  br_state_e state;
  br_state_e state_nxt;
  logic      id_br;
  logic      take;
  logic      proto_set;

  assign id_br = id_valid & id_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    proto_set = 1'b0;
    if (!pipe_stall) begin
      case (state)
        IDLE: begin
          proto_set = ex_resolve;
          if (id_br) state_nxt = PEND;
        end
        PEND: begin
          if (ex_resolve) begin
            if (ex_brchcnd) begin
              // The ID-stage branch, if any, is on the wrong path and gets flushed.
              state_nxt = REDIRECT;
              take      = 1'b1;
            end else if (!id_br) begin
              state_nxt = IDLE;
            end
          end
        end
        REDIRECT: state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // A second branch may not enter EX until the tracked one resolves.
  assign fetch_hold = (state == PEND) & id_br & ~ex_resolve;
  assign busy       = (state != IDLE);

  // Redirect pulses track REDIRECT occupancy, so a stall stretches them naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      redirect_pc    <= '0;
      proto_err      <= 1'b0;
    end else begin
      redirect_valid <= (state_nxt == REDIRECT);
      flush_if_id    <= (state_nxt == REDIRECT);
      flush_id_ex    <= (state_nxt == REDIRECT);
      if (take) redirect_pc <= ex_target;
      if (proto_set) proto_err <= 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (take),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second instance with CNT_W=2 shares the stimulus.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_branch, ex_resolve, ex_brchcnd, pipe_stall;
  logic [15:0] ex_target;

  logic        fetch_hold, redirect_valid, flush_if_id, flush_id_ex, busy, proto_err;
  logic [15:0] redirect_pc, taken_cnt;

  logic        fetch_hold2, redirect_valid2, flush_if_id2, flush_id_ex2, busy2, proto_err2;
  logic [15:0] redirect_pc2;
  logic [1:0]  taken_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .ex_resolve(ex_resolve), .ex_brchcnd(ex_brchcnd), .ex_target(ex_target),
    .pipe_stall(pipe_stall), .fetch_hold(fetch_hold), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .busy(busy), .taken_cnt(taken_cnt), .proto_err(proto_err)
  );

  branch_redirect_ctrl #(.ADDR_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .ex_resolve(ex_resolve), .ex_brchcnd(ex_brchcnd), .ex_target(ex_target),
    .pipe_stall(pipe_stall), .fetch_hold(fetch_hold2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .flush_if_id(flush_if_id2), .flush_id_ex(flush_id_ex2),
    .busy(busy2), .taken_cnt(taken_cnt2), .proto_err(proto_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic b, input logic r, input logic c,
                        input logic [15:0] t, input logic s);
    id_valid = v; id_branch = b; ex_resolve = r; ex_brchcnd = c; ex_target = t; pipe_stall = s;
    #1;
  endtask

  task automatic chk_redirect(input string tag, input logic v, input logic [15:0] pc);
    chk({tag, ".rv"},  32'(redirect_valid), 32'(v));
    chk({tag, ".fif"}, 32'(flush_if_id),    32'(v));
    chk({tag, ".fie"}, 32'(flush_id_ex),    32'(v));
    chk({tag, ".pc"},  32'(redirect_pc),    32'(pc));
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 16'h0, 0);
    tick(); tick();
    chk_redirect("reset", 0, 16'h0000);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.cnt",  32'(taken_cnt), 32'd0);
    chk("reset.perr", 32'(proto_err), 32'd0);
    chk("reset.hold", 32'(fetch_hold), 32'd0);
    rst = 1'b0;

    // Stalled branch in ID must not be tracked
    set_in(1, 1, 0, 0, 16'h0, 1); tick();
    chk("stall_idle.busy", 32'(busy), 32'd0);

    // Taken branch
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    chk("taken.pend_busy", 32'(busy), 32'd1);
    chk("taken.pend_hold", 32'(fetch_hold), 32'd1);
    set_in(0, 0, 1, 1, 16'h0040, 0); tick();
    chk_redirect("taken.n1", 1, 16'h0040);
    chk("taken.n1_cnt",  32'(taken_cnt), 32'd1);
    chk("taken.n1_busy", 32'(busy), 32'd1);
    set_in(0, 0, 0, 0, 16'h0, 0); tick();
    chk_redirect("taken.n2", 0, 16'h0040);
    chk("taken.n2_busy", 32'(busy), 32'd0);

    // Not taken
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    set_in(0, 0, 1, 0, 16'h0080, 0); tick();
    chk_redirect("ntaken", 0, 16'h0040);
    chk("ntaken.busy", 32'(busy), 32'd0);
    chk("ntaken.cnt",  32'(taken_cnt), 32'd1);

    // Back-to-back: second branch enters while the first resolves not-taken
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    set_in(1, 1, 1, 0, 16'h0100, 0);
    chk("b2b.hold", 32'(fetch_hold), 32'd0);
    tick();
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.rv",   32'(redirect_valid), 32'd0);
    set_in(0, 0, 1, 1, 16'h1234, 0); tick();
    chk_redirect("b2b.taken", 1, 16'h1234);
    chk("b2b.cnt", 32'(taken_cnt), 32'd2);
    set_in(0, 0, 0, 0, 16'h0, 0); tick();
    chk("b2b.idle", 32'(busy), 32'd0);
    chk("b2b.rv0",  32'(redirect_valid), 32'd0);

    // Hold: second branch waits on an unresolved first branch
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    chk("hold.c1", 32'(fetch_hold), 32'd1);
    tick();
    chk("hold.c2", 32'(fetch_hold), 32'd1);
    chk("hold.busy", 32'(busy), 32'd1);
    set_in(1, 1, 1, 0, 16'h0, 0);
    chk("hold.release", 32'(fetch_hold), 32'd0);
    tick();
    chk("hold.still_pend", 32'(busy), 32'd1);
    set_in(0, 0, 1, 0, 16'h0, 0); tick();
    chk("hold.idle", 32'(busy), 32'd0);

    // Stall during REDIRECT: three held cycles then IDLE
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    set_in(0, 0, 1, 1, 16'h00AA, 0); tick();
    chk_redirect("stall.enter", 1, 16'h00AA);
    set_in(1, 1, 1, 1, 16'h0555, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_redirect($sformatf("stall.hold%0d", i), 1, 16'h00AA);
      chk($sformatf("stall.cnt%0d", i), 32'(taken_cnt), 32'd3);
    end
    set_in(0, 0, 0, 0, 16'h0, 0); tick();
    chk_redirect("stall.exit", 0, 16'h00AA);
    chk("stall.busy", 32'(busy), 32'd0);

    // Reset in the middle of REDIRECT
    set_in(1, 1, 0, 0, 16'h0, 0); tick();
    set_in(0, 0, 1, 1, 16'h0BEE, 0); tick();
    chk("rstmid.rv", 32'(redirect_valid), 32'd1);
    set_in(0, 0, 0, 0, 16'h0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_redirect("rstmid", 0, 16'h0000);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.cnt",  32'(taken_cnt), 32'd0);

    // Five taken branches: 16-bit counter reads 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, 0, 16'h0, 0); tick();
      set_in(0, 0, 1, 1, 16'(16'h0200 + i), 0); tick();
      set_in(0, 0, 0, 0, 16'h0, 0); tick();
    end
    chk("sat.cnt16", 32'(taken_cnt),  32'd5);
    chk("sat.cnt2",  32'(taken_cnt2), 32'd3);
    chk("sat.pc2",   32'(redirect_pc2), 32'h0204);
    chk("sat.rv2",   32'({redirect_valid2, flush_if_id2, flush_id_ex2}), 32'd0);
    chk("sat.misc2", 32'({busy2, fetch_hold2, proto_err2}), 32'd0);

    // Protocol error: resolve with nothing pending, sticky until reset
    set_in(0, 0, 1, 0, 16'h0, 0); tick();
    chk("perr.set", 32'(proto_err), 32'd1);
    chk("perr.idle", 32'(busy), 32'd0);
    set_in(0, 0, 0, 0, 16'h0, 0); tick(); tick();
    chk("perr.sticky", 32'(proto_err), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perr.clear", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-hazard handling around the branch-condition unit in the 5-stage pipeline.
- Tracks the single unresolved branch/jump between ID and EX, with predict-not-taken.
- On a taken resolution in EX, it issues a registered PC redirect and flushes the two younger stages.
- Keeps a saturating taken-branch counter and a sticky protocol-error flag.

Parameters:
ADDR_W, 16, PC/target width
CNT_W, 16, taken-branch counter width

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a valid instruction
id_branch  input  1  ID instruction is branch/jump (branch field nonzero)
ex_resolve  input  1  the tracked branch is in EX this cycle
ex_brchcnd  input  1  branch-condition result from EX (1 = taken)
ex_target  input  ADDR_W  computed target from EX
pipe_stall  input  1  global pipeline freeze (memory stall)
fetch_hold  output  1  combinational; stall IF/ID
redirect_valid  output  1  registered; load PC from redirect_pc
redirect_pc  output  ADDR_W  registered target
flush_if_id  output  1  registered; squash IF/ID register
flush_id_ex  output  1  registered; squash ID/EX register
busy  output  1  state != IDLE
taken_cnt  output  CNT_W  taken branches since reset, saturating
proto_err  output  1  sticky; ex_resolve seen with no branch pending

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; redirect_valid, flush_*, proto_err, taken_cnt, and redirect_pc all 0. Reset mid-operation drops any pending redirect.
- States: IDLE, PEND, REDIRECT.
- While pipe_stall=1: no state change, counter frozen, registered outputs held, fetch_hold unaffected.
- IDLE:
  - id_valid & id_branch & ~pipe_stall -> PEND.
  - ex_resolve=1 -> proto_err<=1, stay IDLE.
- PEND, ex_resolve & ~pipe_stall:
  - ex_brchcnd=1 -> REDIRECT. Register redirect_pc<=ex_target and set redirect_valid, flush_if_id, flush_id_ex for exactly the next cycle. taken_cnt+=1, holding at 2^CNT_W-1. Any branch in ID that same cycle is squashed and not tracked.
  - ex_brchcnd=0 -> IDLE. Exception: if id_valid & id_branch in the same cycle, stay PEND (back-to-back branches, no bubble).
- PEND, ~ex_resolve:
  - A second id_valid & id_branch makes fetch_hold=1 (combinational) until resolution.
  - Only one branch may be outstanding.
- REDIRECT:
  - Outputs asserted while in this state.
  - If ~pipe_stall -> IDLE next cycle, outputs drop to 0.
  - If stalled, hold REDIRECT and outputs.
- fetch_hold = (state==PEND) & id_valid & id_branch & ~ex_resolve.
- Latency: taken resolution at cycle N -> redirect_valid/flush at N+1 -> IDLE at N+2 (no stall).
- redirect_pc holds its last value when redirect_valid=0.
- Condition codes (JUMP, BEQZ, BNEZ, BLTZ, BGEZ, BSCO) are evaluated upstream; this block only consumes ex_brchcnd.

Decomposition:
- Package branch_ctrl_pkg:
  - state enum (IDLE/PEND/REDIRECT);
  - 3-bit branch opcode constants (JUMP, BEQZ, BNEZ, BLTZ, BGEZ, BSCO), shared with the condition unit and decoder.
- Sub-module sat_counter (width param, inc, clear) for taken_cnt. The FSM stays inline.

Test Plan:
- Taken: branch in ID cycle 1; ex_resolve=1, brchcnd=1, target=0x0040 at cycle 2 -> cycle 3: redirect_valid=1, redirect_pc=0x0040, both flushes=1, taken_cnt=1; cycle 4: all 0, busy=0.
- Not taken: same as above with brchcnd=0 -> no redirect/flush, IDLE at cycle 3, taken_cnt=0.
- Back-to-back: second branch in ID while first resolves not-taken -> stays PEND, fetch_hold=0; second resolves taken -> one redirect; taken_cnt=1.
- Hold: second branch in ID while first unresolved -> fetch_hold=1 each such cycle until ex_resolve.
- Stall/reset: pipe_stall=1 during REDIRECT for 3 cycles -> outputs held 3 cycles then IDLE. rst=1 mid-REDIRECT -> all outputs 0 the next cycle. With CNT_W=2, 5 taken branches -> taken_cnt=3.
- Protocol error: ex_resolve=1 in IDLE -> proto_err=1 and stays 1 until rst.
